// File: rtl/output_framer.sv
// output_framer: tags a beat stream with sof/eol/eof using a cols x rows raster and one output register stage
module output_framer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cfg_cols,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cols_q, cols_d, rows_q, rows_d, col_q, col_d, row_q, row_d;
    logic                m_valid_q, m_sof_q, m_eol_q, m_eof_q, frame_done_q;
    logic [DATA_W-1:0]   m_data_q;
    logic [FCNT_W-1:0]   frame_count_q;
    logic [CNT_W-1:0]    cur_cols, cur_rows;
    logic                in_xfer, out_xfer, sof, eol, eof, done;

    assign s_ready  = (!m_valid_q || m_ready) && !abort;
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid_q && m_ready;
    // In IDLE the incoming beat already uses the live config; a zero size behaves as one
    assign cur_cols = state_q == IDLE ? (cfg_cols == '0 ? ONE : cfg_cols) : cols_q;
    assign cur_rows = state_q == IDLE ? (cfg_rows == '0 ? ONE : cfg_rows) : rows_q;
    assign sof      = col_q == '0 && row_q == '0;
    assign eol      = col_q == cur_cols - ONE;
    assign eof      = eol && row_q == cur_rows - ONE;
    assign done     = out_xfer && m_eof_q && !abort;

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_sof       = m_sof_q;
    assign m_eol       = m_eol_q;
    assign m_eof       = m_eof_q;
    assign busy        = state_q == ACTIVE;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

    // Raster counters and frame state advance per input beat; abort wins over everything
    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        rows_d  = rows_q;
        col_d   = col_q;
        row_d   = row_q;
        if (abort) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else if (in_xfer) begin
            cols_d  = cur_cols;
            rows_d  = cur_rows;
            col_d   = eol ? '0 : col_q + ONE;
            row_d   = eof ? '0 : (eol ? row_q + ONE : row_q);
            state_d = eof ? IDLE : ACTIVE;
        end
    end

    // State, output beat register and frame completion bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cols_q        <= '0;
            rows_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_sof_q       <= 1'b0;
            m_eol_q       <= 1'b0;
            m_eof_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            col_q        <= col_d;
            row_q        <= row_d;
            m_valid_q    <= abort ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : m_valid_q;
            frame_done_q <= done;
            if (in_xfer) begin
                m_data_q <= s_data;
                m_sof_q  <= sof;
                m_eol_q  <= eol;
                m_eof_q  <= eof;
            end
            if (done) frame_count_q <= frame_count_q + FCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_output_framer.sv
// tb_output_framer: directed scenario tests for output_framer
module tb_output_framer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  cfg_cols = 8'd4, cfg_rows = 8'd4;
    logic        abort = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_ready, m_valid, m_sof, m_eol, m_eof, busy, frame_done;
    logic [15:0] m_data, frame_count;

    int total = 0, bad = 0, cyc = 0, fd_cnt = 0, hold_err = 0, timeouts = 0;
    bit rnd_rdy = 0, hold_pend = 0;
    logic [15:0] hold_d;
    logic [2:0]  hold_f;
    logic [15:0] log_d[$];
    logic [2:0]  log_f[$];

    output_framer dut (
        .clk(clk), .rst_n(rst_n), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .m_ready(m_ready), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (frame_done) fd_cnt++;
        if (!rst_n) hold_pend = 0;
        else begin
            if (hold_pend && (!m_valid || m_data !== hold_d || {m_sof, m_eol, m_eof} !== hold_f)) hold_err++;
            if (m_valid && m_ready) begin
                log_d.push_back(m_data);
                log_f.push_back({m_sof, m_eol, m_eof});
            end
            hold_pend = m_valid && !m_ready && !abort;
            hold_d = m_data;
            hold_f = {m_sof, m_eol, m_eof};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [15:0] d);
        s_valid = 1'b1;
        s_data = d;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (s_ready) begin
                tick(1);
                s_valid = 1'b0;
                return;
            end
            tick(1);
        end
        s_valid = 1'b0;
        timeouts++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        abort = 1'b0;
        m_ready = 1'b1;
        rnd_rdy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data = 16'hABCD;
        @(negedge clk);
        total++;
        if ({m_valid, m_sof, m_eol, m_eof, busy, frame_done} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000", {m_valid, m_sof, m_eol, m_eof, busy, frame_done});
        end
        total++;
        if (m_data !== 16'h0 || frame_count !== 16'h0) begin
            bad++; $display("FAIL reset_regs got data=%h fc=%0d want 0 0", m_data, frame_count);
        end
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_sready got=%b want=1", s_ready); end
    endtask

    task automatic test_4x4();
        int n0, c0;
        do_reset();
        cfg_cols = 8'd4; cfg_rows = 8'd4;
        n0 = log_d.size();
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(16'(100 + i));
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL busy_active got=%b want=1", busy); end
            end
        end
        total++;
        if (cyc - c0 != 16) begin bad++; $display("FAIL full_rate got=%0d cycles want=16", cyc - c0); end
        total++;
        if (frame_done !== 1'b0 || m_eof !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL pre_done got fd=%b eof=%b busy=%b want 0 1 0", frame_done, m_eof, busy);
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b1 || frame_count !== 16'd1) begin
            bad++; $display("FAIL done_pulse got fd=%b fc=%0d want 1 1", frame_done, frame_count);
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL done_width got=%b want=0", frame_done); end
        total++;
        if (log_d.size() != n0 + 16) begin bad++; $display("FAIL cnt_4x4 got=%0d want=16", log_d.size() - n0); end
        else for (int i = 0; i < 16; i++) begin
            total++;
            if (log_d[n0+i] !== 16'(100 + i) || log_f[n0+i] !== {i == 0, i % 4 == 3, i == 15}) begin
                bad++; $display("FAIL beat_4x4[%0d] got d=%0d f=%b want d=%0d f=%b", i, log_d[n0+i], log_f[n0+i], 100 + i, {i == 0, i % 4 == 3, i == 15});
            end
        end
    endtask

    task automatic test_1x1();
        int n0, c0, f0;
        do_reset();
        cfg_cols = 8'd0; cfg_rows = 8'd0;
        n0 = log_d.size();
        f0 = fd_cnt;
        c0 = cyc;
        for (int i = 0; i < 3; i++) send(16'(7 + i));
        total++;
        if (cyc - c0 != 3) begin bad++; $display("FAIL back_to_back got=%0d cycles want=3", cyc - c0); end
        tick(3);
        total++;
        if (frame_count !== 16'd3 || fd_cnt - f0 != 3) begin
            bad++; $display("FAIL count_1x1 got fc=%0d pulses=%0d want 3 3", frame_count, fd_cnt - f0);
        end
        total++;
        if (log_d.size() != n0 + 3) begin bad++; $display("FAIL cnt_1x1 got=%0d want=3", log_d.size() - n0); end
        else for (int i = 0; i < 3; i++) begin
            total++;
            if (log_d[n0+i] !== 16'(7 + i) || log_f[n0+i] !== 3'b111) begin
                bad++; $display("FAIL beat_1x1[%0d] got d=%0d f=%b want d=%0d f=111", i, log_d[n0+i], log_f[n0+i], 7 + i);
            end
        end
    endtask

    task automatic test_stall();
        int n0, c, r;
        do_reset();
        cfg_cols = 8'd3; cfg_rows = 8'd2;
        n0 = log_d.size();
        hold_err = 0;
        timeouts = 0;
        rnd_rdy = 1;
        for (int i = 0; i < 12; i++) send(16'(200 + i));
        rnd_rdy = 0;
        m_ready = 1'b1;
        tick(4);
        total++;
        if (hold_err != 0 || timeouts != 0) begin bad++; $display("FAIL stall_hold got errs=%0d timeouts=%0d want 0 0", hold_err, timeouts); end
        total++;
        if (frame_count !== 16'd2) begin bad++; $display("FAIL stall_fc got=%0d want=2", frame_count); end
        total++;
        if (log_d.size() != n0 + 12) begin bad++; $display("FAIL cnt_stall got=%0d want=12", log_d.size() - n0); end
        else for (int i = 0; i < 12; i++) begin
            c = i % 3; r = (i / 3) % 2;
            total++;
            if (log_d[n0+i] !== 16'(200 + i) || log_f[n0+i] !== {c == 0 && r == 0, c == 2, c == 2 && r == 1}) begin
                bad++; $display("FAIL beat_stall[%0d] got d=%0d f=%b want d=%0d f=%b", i, log_d[n0+i], log_f[n0+i], 200 + i, {c == 0 && r == 0, c == 2, c == 2 && r == 1});
            end
        end
    endtask

    task automatic test_abort();
        int n0, f0;
        do_reset();
        cfg_cols = 8'd4; cfg_rows = 8'd4;
        n0 = log_d.size();
        f0 = fd_cnt;
        for (int i = 0; i < 6; i++) send(16'(500 + i));
        m_ready = 1'b0;
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = 16'd999;
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_sready got=%b want=0", s_ready); end
        @(negedge clk);
        abort = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_drop got v=%b busy=%b want 0 0", m_valid, busy); end
        total++;
        if (frame_count !== 16'd0 || fd_cnt != f0) begin bad++; $display("FAIL abort_count got fc=%0d pulses=%0d want 0 0", frame_count, fd_cnt - f0); end
        send(16'd555);
        tick(2);
        total++;
        if (log_d.size() != n0 + 6) begin bad++; $display("FAIL abort_cnt got=%0d want=6", log_d.size() - n0); end
        else if (log_d[n0+5] !== 16'd555 || log_f[n0+5] !== 3'b100) begin
            total++; bad++; $display("FAIL abort_sof got d=%0d f=%b want d=555 f=100", log_d[n0+5], log_f[n0+5]);
        end else total++;
    endtask

    task automatic test_cfg_change();
        int n0, j;
        logic [2:0] ef;
        do_reset();
        cfg_cols = 8'd4; cfg_rows = 8'd2;
        n0 = log_d.size();
        timeouts = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) cfg_cols = 8'd2;
            send(16'(400 + i));
        end
        tick(3);
        total++;
        if (frame_count !== 16'd2 || timeouts != 0) begin bad++; $display("FAIL cfg_fc got=%0d to=%0d want 2 0", frame_count, timeouts); end
        total++;
        if (log_d.size() != n0 + 12) begin bad++; $display("FAIL cnt_cfg got=%0d want=12", log_d.size() - n0); end
        else for (int i = 0; i < 12; i++) begin
            j = i - 8;
            ef = i < 8 ? {i == 0, i % 4 == 3, i == 7} : {j == 0, j % 2 == 1, j == 3};
            total++;
            if (log_d[n0+i] !== 16'(400 + i) || log_f[n0+i] !== ef) begin
                bad++; $display("FAIL beat_cfg[%0d] got d=%0d f=%b want d=%0d f=%b", i, log_d[n0+i], log_f[n0+i], 400 + i, ef);
            end
        end
    endtask

    task automatic test_async_reset();
        int n0;
        cfg_cols = 8'd4; cfg_rows = 8'd4;
        for (int i = 0; i < 9; i++) send(16'(300 + i));
        total++;
        if (m_valid !== 1'b1 || m_data !== 16'd308 || busy !== 1'b1 || frame_count !== 16'd2) begin
            bad++; $display("FAIL pre_arst got v=%b d=%0d busy=%b fc=%0d want 1 308 1 2", m_valid, m_data, busy, frame_count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({m_valid, m_sof, m_eol, m_eof, busy, frame_done} !== 6'b0 || m_data !== 16'h0 || frame_count !== 16'h0) begin
            bad++; $display("FAIL arst_now got f=%b d=%0d fc=%0d want 000000 0 0", {m_valid, m_sof, m_eol, m_eof, busy, frame_done}, m_data, frame_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n0 = log_d.size();
        send(16'd77);
        tick(2);
        total++;
        if (log_d.size() != n0 + 1) begin bad++; $display("FAIL arst_cnt got=%0d want=1", log_d.size() - n0); end
        else if (log_d[n0] !== 16'd77 || log_f[n0] !== 3'b100) begin
            total++; bad++; $display("FAIL arst_sof got d=%0d f=%b want d=77 f=100", log_d[n0], log_f[n0]);
        end else total++;
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_1x1();
        test_stall();
        test_abort();
        test_cfg_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
